// File: rtl/wvb_dpram_writer_pkg.sv
// Shared definitions for the waveform-buffer to readout-DPRAM writer:
// header field layout, DPRAM geometry and the writer state encoding.
package wvb_dpram_writer_pkg;

    localparam int N_SAMP_HI = 59;
    localparam int N_SAMP_LO = 48;
    localparam int LTC_HI    = 47;
    localparam int LTC_LO    = 0;
    localparam int HDR_BITS  = 60;
    localparam int SMP_BITS  = 16;

    localparam logic [7:0] HDR_MARKER = 8'hA5;
    localparam int DPRAM_DEPTH = 1024;
    localparam int HDR_WORDS   = 3;
    // Two samples per word after the header fill the DPRAM exactly.
    localparam int MAX_SAMPLES_FULL = (DPRAM_DEPTH - HDR_WORDS) * 2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_H0        = 4'd1,
        ST_H1        = 4'd2,
        ST_H2        = 4'd3,
        ST_S_HI      = 4'd4,
        ST_S_LO      = 4'd5,
        ST_DRAIN     = 4'd6,
        ST_DONE      = 4'd7,
        ST_WAIT_BUSY = 4'd8
    } wr_state_e;

    function automatic logic [15:0] event_len(input logic [11:0] copied);
        logic [11:0] words;
        words = 12'(HDR_WORDS) + ((copied + 12'd1) >> 1);
        return {4'h0, words};
    endfunction

endpackage

// File: rtl/wvb_dpram_writer_rr_arbiter.sv
// N-input round-robin arbiter: combinational grant searched from a
// registered pointer that moves past the winner when the grant is taken.
module wvb_dpram_writer_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic [4:0]   grant_idx,
    output logic         valid
);

    logic [4:0] ptr;

    // Search from the pointer upward with wrap; the first request found wins.
    always_comb begin
        int   c;
        logic hit;
        grant     = '0;
        grant_idx = 5'd0;
        valid     = 1'b0;
        c         = 0;
        hit       = 1'b0;
        for (int off = 0; off < N; off++) begin
            c         = (int'(ptr) + off) % N;
            hit       = req[c] & ~valid;
            grant[c]  = grant[c] | hit;
            grant_idx = hit ? 5'(c) : grant_idx;
            valid     = valid | hit;
        end
    end

    // Pointer moves to the channel after the one just granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 5'd0;
        end else if (advance && valid) begin
            ptr <= (grant_idx == 5'(N - 1)) ? 5'd0 : grant_idx + 5'd1;
        end
    end

endmodule

// File: rtl/wvb_dpram_writer.sv
// Copies one waveform at a time from the per-channel header/sample FIFOs into
// the readout DPRAM and hands it to xdom with a run pulse and word count.
module wvb_dpram_writer
    import wvb_dpram_writer_pkg::*;
#(
    parameter int N_CHANNELS  = 2,
    parameter int MAX_SAMPLES = MAX_SAMPLES_FULL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [N_CHANNELS-1:0]        hdr_empty,
    input  logic [N_CHANNELS*60-1:0]     hdr_data,
    output logic [N_CHANNELS-1:0]        hdr_rdreq,
    input  logic [N_CHANNELS*16-1:0]     smp_data,
    output logic [N_CHANNELS-1:0]        smp_rdreq,
    output logic                         rdout_dpram_wren,
    output logic [9:0]                   rdout_dpram_wr_addr,
    output logic [31:0]                  rdout_dpram_data,
    output logic                         rdout_dpram_run,
    output logic [15:0]                  dpram_len_out,
    input  logic                         dpram_busy,
    output logic [4:0]                   cur_chan
);

    localparam logic [11:0] MAX_S = 12'(MAX_SAMPLES);
    localparam logic [N_CHANNELS-1:0] CH_ONE = (N_CHANNELS)'(1'b1);

    wr_state_e               state;
    logic [11:0]             n_samp;
    logic [47:0]             ltc;
    logic                    trunc;
    logic [11:0]             copy_total;
    logic [11:0]             copied;
    logic [11:0]             drain_left;
    logic [9:0]              wptr;
    logic [15:0]             data_hi;

    logic [N_CHANNELS-1:0]   grant;
    logic [4:0]              grant_idx;
    logic                    grant_valid;
    logic                    start;
    logic [HDR_BITS-1:0]     hdr_sel;
    logic [SMP_BITS-1:0]     smp_sel;
    logic [11:0]             hdr_n;
    logic                    hdr_trunc;

    wvb_dpram_writer_rr_arbiter #(.N(N_CHANNELS)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (~hdr_empty),
        .advance   (start),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (grant_valid)
    );

    // Header comes from the arbitration winner, samples from the latched channel.
    always_comb begin
        hdr_sel = '0;
        smp_sel = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            hdr_sel = (grant_idx == 5'(c)) ? hdr_data[c*HDR_BITS +: HDR_BITS] : hdr_sel;
            smp_sel = (cur_chan == 5'(c)) ? smp_data[c*SMP_BITS +: SMP_BITS] : smp_sel;
        end
    end

    assign start     = (state == ST_IDLE) & enable & ~dpram_busy & grant_valid;
    assign hdr_n     = hdr_sel[N_SAMP_HI:N_SAMP_LO];
    assign hdr_trunc = (hdr_n > MAX_S);

    // Event sequencer. smp_rdreq is set one state ahead so that it is high in
    // exactly the cycle whose FWFT sample head is being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            n_samp              <= 12'd0;
            ltc                 <= 48'd0;
            trunc               <= 1'b0;
            copy_total          <= 12'd0;
            copied              <= 12'd0;
            drain_left          <= 12'd0;
            wptr                <= 10'd0;
            data_hi             <= 16'd0;
            hdr_rdreq           <= '0;
            smp_rdreq           <= '0;
            rdout_dpram_wren    <= 1'b0;
            rdout_dpram_wr_addr <= 10'd0;
            rdout_dpram_data    <= 32'd0;
            rdout_dpram_run     <= 1'b0;
            dpram_len_out       <= 16'd0;
            cur_chan            <= 5'd0;
        end else begin
            rdout_dpram_wren <= 1'b0;
            rdout_dpram_run  <= 1'b0;
            hdr_rdreq        <= '0;
            case (state)
                ST_IDLE: begin
                    smp_rdreq <= '0;
                    if (start) begin
                        hdr_rdreq  <= grant;
                        n_samp     <= hdr_n;
                        ltc        <= hdr_sel[LTC_HI:LTC_LO];
                        trunc      <= hdr_trunc;
                        copy_total <= hdr_trunc ? MAX_S : hdr_n;
                        cur_chan   <= grant_idx;
                        state      <= ST_H0;
                    end
                end
                ST_H0: begin
                    rdout_dpram_wren    <= 1'b1;
                    rdout_dpram_wr_addr <= 10'd0;
                    rdout_dpram_data    <= {HDR_MARKER, trunc, 2'b00, cur_chan, 4'h0, n_samp};
                    state               <= ST_H1;
                end
                ST_H1: begin
                    rdout_dpram_wren    <= 1'b1;
                    rdout_dpram_wr_addr <= 10'd1;
                    rdout_dpram_data    <= ltc[47:16];
                    state               <= ST_H2;
                end
                ST_H2: begin
                    rdout_dpram_wren    <= 1'b1;
                    rdout_dpram_wr_addr <= 10'd2;
                    rdout_dpram_data    <= {ltc[15:0], 16'h0000};
                    wptr                <= 10'(HDR_WORDS);
                    copied              <= 12'd0;
                    if (n_samp == 12'd0) begin
                        state <= ST_DONE;
                    end else begin
                        smp_rdreq <= CH_ONE << cur_chan;
                        state     <= ST_S_HI;
                    end
                end
                ST_S_HI: begin
                    data_hi <= smp_sel;
                    copied  <= copied + 12'd1;
                    if (copied + 12'd1 == copy_total) begin
                        rdout_dpram_wren    <= 1'b1;
                        rdout_dpram_wr_addr <= wptr;
                        rdout_dpram_data    <= {smp_sel, 16'h0000};
                        wptr                <= wptr + 10'd1;
                        if (trunc) begin
                            drain_left <= n_samp - MAX_S;
                            state      <= ST_DRAIN;
                        end else begin
                            smp_rdreq <= '0;
                            state     <= ST_DONE;
                        end
                    end else begin
                        state <= ST_S_LO;
                    end
                end
                ST_S_LO: begin
                    rdout_dpram_wren    <= 1'b1;
                    rdout_dpram_wr_addr <= wptr;
                    rdout_dpram_data    <= {data_hi, smp_sel};
                    wptr                <= wptr + 10'd1;
                    copied              <= copied + 12'd1;
                    if (copied + 12'd1 == copy_total) begin
                        if (trunc) begin
                            drain_left <= n_samp - MAX_S;
                            state      <= ST_DRAIN;
                        end else begin
                            smp_rdreq <= '0;
                            state     <= ST_DONE;
                        end
                    end else begin
                        state <= ST_S_HI;
                    end
                end
                ST_DRAIN: begin
                    drain_left <= drain_left - 12'd1;
                    if (drain_left == 12'd1) begin
                        smp_rdreq <= '0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    rdout_dpram_run <= 1'b1;
                    dpram_len_out   <= event_len(copy_total);
                    state           <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (dpram_busy) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    smp_rdreq <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wvb_dpram_writer.md
Name: wvb_dpram_writer

Overview:
- Producer end of the direct-readout DPRAM handshake that xdom consumes.
- Round-robins over per-channel waveform-buffer header/sample FIFOs and copies one waveform at a time into the 1024x32 readout DPRAM, as a fixed 3-word header followed by packed samples.
- Announces each completed event to xdom with a 1-cycle run pulse plus its length, then holds off until xdom's busy flag rises and clears.

Parameters:
- N_CHANNELS, 2, number of waveform-buffer channels serviced (1..16).
- MAX_SAMPLES, 2042, samples copied per event; (1024-3)*2 fills the DPRAM exactly.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  level; 0 blocks starting a new event (an in-flight event completes).
- hdr_empty  in  N_CHANNELS  per-channel header FIFO empty.
- hdr_data  in  N_CHANNELS*60  FWFT header per channel: [59:48] n_samples, [47:0] ltc.
- hdr_rdreq  out  N_CHANNELS  header pop, one-hot, 1-cycle.
- smp_data  in  N_CHANNELS*16  FWFT sample FIFO head per channel.
- smp_rdreq  out  N_CHANNELS  sample pop, one-hot.
- rdout_dpram_wren  out  1  DPRAM write enable.
- rdout_dpram_wr_addr  out  10  DPRAM word address.
- rdout_dpram_data  out  32  DPRAM write data.
- rdout_dpram_run  out  1  1-cycle pulse: event complete.
- dpram_len_out  out  16  words in event; valid while run is high, held afterwards.
- dpram_busy  in  1  from xdom; high until software writes dpram_done.
- cur_chan  out  5  channel of the last/current event (debug).

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0. Reset mid-event abandons the event without popping further; FIFO recovery is via wvb_rst.
- Precondition: a channel's samples are fully in its sample FIFO before its header is visible.
- IDLE:
  - Requires enable=1 and dpram_busy=0.
  - Selects the first non-empty channel at or after the pointer, wrapping modulo N_CHANNELS; the pointer becomes selected+1.
  - Pulses hdr_rdreq, latches n=n_samples and ltc, goes to H0.
- Header words (addresses 0, 1, 2, one per cycle):
  - H0 writes {8'hA5, trunc, 2'b0, chan[4:0], 4'b0, n[11:0]}, where trunc = (n > MAX_SAMPLES).
  - H1 writes ltc[47:16].
  - H2 writes {ltc[15:0], 16'h0}.
  - If n=0, go to DONE; else go to S_HI.
- S_HI: pop one sample into data[31:16].
  - If this is the last copied sample, write the word with data[15:0]=0 and leave.
  - Else go to S_LO.
- S_LO: pop one sample into data[15:0], write the word, address+1.
- Sample copy: two cycles per word; wren asserts on the word-completing cycle; address increments after each write. Copying stops after min(n, MAX_SAMPLES) samples.
- DRAIN (only when trunc):
  - Pops the remaining n-MAX_SAMPLES samples, 1 per cycle, with no writes.
  - Every sample the header promises is always popped.
- DONE:
  - rdout_dpram_run=1 for one cycle.
  - dpram_len_out = 3 + ceil(min(n,MAX_SAMPLES)/2).
  - Then WAIT_BUSY.
- WAIT_BUSY: wait for dpram_busy=1 (xdom latches one cycle after run), then IDLE. IDLE itself waits for busy=0, so a new event never overwrites unread data.
- enable dropped mid-event: no effect until IDLE. All hdr_empty=1: remain IDLE.
- Widths: all length arithmetic is 12-bit, zero-extended to 16 bits. wr_addr never exceeds 1023.

Decomposition:
- Shared package:
  - header field offsets (N_SAMP_HI/LO, LTC_HI/LO);
  - HDR_MARKER=8'hA5;
  - DPRAM_DEPTH=1024, HDR_WORDS=3, MAX_SAMPLES derivation;
  - state enumeration.
- One natural sub-module: rr_arbiter (N-input round-robin, one-hot grant plus index, combinational grant with a registered pointer).
- Channel data muxing reuses n_channel_mux.

Test Plan:
- Ch0 event with n=5, ltc=48'h0123456789AB:
  - writes addr 0..5 = A500_0005, 01234567, 89AB0000, s0:s1, s2:s3, s4:0000;
  - run pulse with len=6; 5 sample pops and 1 header pop.
- n=0 on ch1 -> writes only addr 0..2, word0=A5_0_01_0_000, len=3; no smp_rdreq.
- n=2100 -> trunc bit (word0 bit23) set; last write at addr 1023; 2100 samples popped in total; len=1024.
- Ch0 and ch1 both pending, busy held 1 for 100 cycles after the first run:
  - second event does not start until busy falls;
  - order is ch0, ch1, ch0 (round-robin).
- rst asserted during S_LO -> next cycle all outputs 0, state IDLE; a fresh event afterwards starts at addr 0.
- enable=0 with headers pending -> no pops.
  - enable deasserted mid-event -> event completes with run pulse; no new event starts.
